// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
//   CLA_GROUP  : default bits per Manchester carry-chain group.
//   num_groups : number of groups for a given operand width.
//   cla_grp_t  : per-group stage-1 result. It holds the group propagate and
//                generate, the local sums for group carry-in 0 and 1, and the
//                carry into the group's MSB for carry-in 0 and 1.
package cla_pkg;

  localparam int CLA_GROUP = 5;

  function automatic int num_groups(input int width, input int group);
    return width / group;
  endfunction

  typedef struct packed {
    logic                 p;
    logic                 g;
    logic [CLA_GROUP-1:0] s0;
    logic [CLA_GROUP-1:0] s1;
    logic                 m0;
    logic                 m1;
  } cla_grp_t;

endpackage

// File: rtl/cla_group_pg.sv
// Combinational CLA_GROUP-bit Manchester carry-chain group.
//   a, b : group slices of operand A and of the effective operand B.
//   grp  : group P/G, local sums for carry-in 0 and 1, and the carry into
//          the group MSB for carry-in 0 and 1.
module cla_group_pg
  import cla_pkg::*;
(
  input  logic [CLA_GROUP-1:0] a,
  input  logic [CLA_GROUP-1:0] b,
  output cla_grp_t             grp
);

  logic [CLA_GROUP-1:0] p;
  logic [CLA_GROUP-1:0] g;
  logic [CLA_GROUP:0]   c0;  // chain carries assuming group carry-in = 0
  logic [CLA_GROUP:0]   c1;  // chain carries assuming group carry-in = 1

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    grp   = '0;
    p     = a ^ b;
    g     = a & b;
    c0    = '0;
    c1    = '0;
    c1[0] = 1'b1;
    for (int i = 0; i < CLA_GROUP; i++) begin
      c0[i+1] = g[i] | (p[i] & c0[i]);
      c1[i+1] = g[i] | (p[i] & c1[i]);
    end
    grp.p  = &p;
    grp.g  = c0[CLA_GROUP];  // carry out with zero carry-in is the group generate
    grp.s0 = p ^ c0[CLA_GROUP-1:0];
    grp.s1 = p ^ c1[CLA_GROUP-1:0];
    grp.m0 = c0[CLA_GROUP-1];
    grp.m1 = c1[CLA_GROUP-1];
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Three-stage pipelined carry-lookahead adder/subtractor with valid/ready.
//   clk, rst            : clock, asynchronous active-high reset.
//   in_valid / in_ready : input handshake for A, B, Cin, sub.
//   A, B, Cin, sub      : operands. sub=1 computes A - B - Cin.
//   out_valid/out_ready : output handshake for S, Cout, Ovf.
//   S, Cout, Ovf        : result, carry out (no-borrow on subtract), and
//                         signed overflow.
// Stage 1 computes group P/G and conditional sums. Stage 2 does the group
// lookahead. Stage 3 selects sums by group carry-in. A stall freezes all stages.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 20,
  parameter int GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int NG = num_groups(WIDTH, GROUP);

  if ((WIDTH % GROUP) != 0 || WIDTH < GROUP || GROUP != CLA_GROUP) begin : g_bad_params
    $error("cla_pipe_adder: WIDTH must be a non-zero multiple of GROUP, and GROUP must equal CLA_GROUP");
  end

  logic adv;  // whole pipeline advances this cycle

  // Stage 1
  logic [WIDTH-1:0] be;
  cla_grp_t         grp_pg [NG];
  cla_grp_t         grp1_d [NG];
  cla_grp_t         grp1_q [NG];
  logic             c0_1_d, c0_1_q;
  logic             v1_d, v1_q;

  // Stage 2
  logic [NG:0]      carry;
  logic             la_prop;
  logic [NG-1:0]    gc2_d, gc2_q;
  logic             cout2_d, cout2_q;
  logic [WIDTH-1:0] s0_cat, s1_cat;
  logic [WIDTH-1:0] s0_2_d, s0_2_q, s1_2_d, s1_2_q;
  logic             m0_2_d, m0_2_q, m1_2_d, m1_2_q;
  logic             v2_d, v2_q;

  // Stage 3
  logic [WIDTH-1:0] sum_sel;
  logic             msb_c;
  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;
  logic             out_valid_d, out_valid_q;

  assign adv       = ~(out_valid_q & ~out_ready);
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign S         = s_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;

  assign be = B ^ {WIDTH{sub}};

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    cla_group_pg u_pg (
      .a   (A[gi*GROUP +: GROUP]),
      .b   (be[gi*GROUP +: GROUP]),
      .grp (grp_pg[gi])
    );
  end

  // Two-level lookahead. Each group carry-in is formed directly from all lower
  // (P,G) pairs and c0 instead of rippling through group carries.
  always_comb begin
    carry    = '0;
    la_prop  = 1'b0;
    carry[0] = c0_1_q;
    for (int i = 1; i <= NG; i++) begin
      carry[i] = grp1_q[i-1].g;
      la_prop  = grp1_q[i-1].p;
      for (int j = i - 2; j >= 0; j--) begin
        carry[i] = carry[i] | (la_prop & grp1_q[j].g);
        la_prop  = la_prop & grp1_q[j].p;
      end
      carry[i] = carry[i] | (la_prop & c0_1_q);
    end
  end

  always_comb begin
    s0_cat  = '0;
    s1_cat  = '0;
    sum_sel = '0;
    for (int i = 0; i < NG; i++) begin
      s0_cat[i*GROUP +: GROUP]  = grp1_q[i].s0;
      s1_cat[i*GROUP +: GROUP]  = grp1_q[i].s1;
      sum_sel[i*GROUP +: GROUP] = gc2_q[i] ? s1_2_q[i*GROUP +: GROUP]
                                           : s0_2_q[i*GROUP +: GROUP];
    end
    msb_c = gc2_q[NG-1] ? m1_2_q : m0_2_q;
  end

  always_comb begin
    grp1_d      = adv ? grp_pg : grp1_q;
    c0_1_d      = adv ? (Cin ^ sub) : c0_1_q;
    v1_d        = adv ? in_valid : v1_q;

    gc2_d       = adv ? carry[NG-1:0] : gc2_q;
    cout2_d     = adv ? carry[NG] : cout2_q;
    s0_2_d      = adv ? s0_cat : s0_2_q;
    s1_2_d      = adv ? s1_cat : s1_2_q;
    m0_2_d      = adv ? grp1_q[NG-1].m0 : m0_2_q;
    m1_2_d      = adv ? grp1_q[NG-1].m1 : m1_2_q;
    v2_d        = adv ? v1_q : v2_q;

    out_valid_d = adv ? v2_q : out_valid_q;
    // Visible outputs only load real results, so they hold across bubbles.
    s_d         = (adv & v2_q) ? sum_sel : s_q;
    cout_d      = (adv & v2_q) ? cout2_q : cout_q;
    ovf_d       = (adv & v2_q) ? (msb_c ^ cout2_q) : ovf_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  // NOTE: inner pipeline data flops are deliberately not reset. They are
  // qualified by the valid bits, which are reset.
  always_ff @(posedge clk) begin
    grp1_d_to_q: grp1_q <= grp1_d;
    c0_1_q  <= c0_1_d;
    gc2_q   <= gc2_d;
    cout2_q <= cout2_d;
    s0_2_q  <= s0_2_d;
    s1_2_q  <= s1_2_d;
    m0_2_q  <= m0_2_d;
    m1_2_q  <= m1_2_d;
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (WIDTH=20, GROUP=5). A driver pushes
// expected results from an arithmetic model into a queue. A monitor pops the
// queue and compares on every output transfer.
module tb_cla_pipe_adder;

  localparam int W = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] S;
  logic         Cout;
  logic         Ovf;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(W), .GROUP(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Cout      (Cout),
    .Ovf       (Ovf)
  );

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sb;
  } op_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(input op_t op);
    exp_t   e;
    longint ua, ub, sa, sb, ci, r, sr;
    ua = longint'(op.a);
    ub = longint'(op.b);
    sa = longint'($signed(op.a));
    sb = longint'($signed(op.b));
    ci = op.cin ? 64'sd1 : 64'sd0;
    if (!op.sb) begin
      r      = ua + ub + ci;
      sr     = sa + sb + ci;
      e.cout = (r >= 64'sd1048576);
    end else begin
      r      = ua - ub - ci;
      sr     = sa - sb - ci;
      e.cout = (r >= 64'sd0);
    end
    e.s   = r[W-1:0];
    e.ovf = (sr < -64'sd524288) || (sr >= 64'sd524288);
    return e;
  endfunction

  // Monitor: pops and compares on every output transfer and checks that a
  // stalled output holds steady.
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_s = '0;
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_s", S, prev_s);
      end
      if (out_valid && out_ready) begin
        check("result_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("S", S, e.s);
          check("Cout", Cout, e.cout);
          check("Ovf", Ovf, e.ovf);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_s     = S;
    end
  end

  task automatic do_cycle(input logic iv, input op_t op, input logic ordy, output logic acc);
    @(negedge clk);
    in_valid  = iv;
    A         = op.a;
    B         = op.b;
    Cin       = op.cin;
    sub       = op.sb;
    out_ready = ordy;
    #1;
    check("in_ready", in_ready, !(out_valid && !out_ready));
    acc = iv && in_ready;
    if (acc) q.push_back(model(op));
  endtask

  // Issues one operation into an empty pipeline and counts clock edges, from
  // the accepting edge on, until out_valid rises.
  task automatic latency_probe(input op_t op, input string name);
    logic acc;
    int   n;
    do_cycle(1'b1, op, 1'b1, acc);
    check({name, "_accept"}, acc, 1);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n++;
    end while (!out_valid && n < 10);
    check({name, "_latency"}, n, 3);
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("drain_timeout", q.size(), 0);
  endtask

  op_t dir_ops[5];
  op_t bp_ops[6];

  initial begin
    logic acc;
    op_t  op;
    int   k, c;

    dir_ops[0] = '{20'h00003, 20'h00005, 1'b0, 1'b0};
    dir_ops[1] = '{20'hFFFFF, 20'h00001, 1'b0, 1'b0};
    dir_ops[2] = '{20'h7FFFF, 20'h00001, 1'b0, 1'b0};
    dir_ops[3] = '{20'h00005, 20'h00007, 1'b0, 1'b1};
    dir_ops[4] = '{20'h00007, 20'h00005, 1'b1, 1'b1};

    // Reset state while rst is held
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_S", S, 0);
    check("rst_Cout_Ovf", {Cout, Ovf}, 0);
    #9 rst = 1'b0;

    // Directed cases from the plan; the model supplies S/Cout/Ovf.
    foreach (dir_ops[i]) begin
      latency_probe(dir_ops[i], $sformatf("dir%0d", i));
      drain();
    end

    // Independent spot checks of the plan's literal results.
    check("lit_add", model(dir_ops[0]).s, 20'h00008);
    check("lit_wrap", {model(dir_ops[1]).cout, model(dir_ops[1]).s}, {1'b1, 20'h00000});
    check("lit_ovf", {model(dir_ops[2]).ovf, model(dir_ops[2]).s}, {1'b1, 20'h80000});
    check("lit_sub", {model(dir_ops[3]).cout, model(dir_ops[3]).s}, {1'b0, 20'hFFFFE});
    check("lit_sub_cin", {model(dir_ops[4]).cout, model(dir_ops[4]).s}, {1'b1, 20'h00001});

    // Backpressure: 6 back-to-back ops, out_ready low for 2 cycles mid-stream.
    foreach (bp_ops[i]) bp_ops[i] = '{W'($urandom()), W'($urandom()), 1'($urandom()), 1'($urandom())};
    k = 0;
    c = 0;
    while (k < 6 && c < 30) begin
      do_cycle(1'b1, bp_ops[k], !(c == 3 || c == 4), acc);
      if (acc) k++;
      c++;
    end
    check("bp_all_accepted", k, 6);
    drain();

    // Reset mid-flight
    do_cycle(1'b1, '{20'h12345, 20'h00111, 1'b0, 1'b0}, 1'b1, acc);
    do_cycle(1'b1, '{20'h0ABCD, 20'h00001, 1'b1, 1'b1}, 1'b1, acc);
    do_cycle(1'b0, '{20'h0, 20'h0, 1'b0, 1'b0}, 1'b1, acc);
    @(posedge clk);
    #1;
    check("pre_reset_valid", out_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_S", S, 0);
    check("mid_rst_Cout_Ovf", {Cout, Ovf}, 0);
    check("mid_rst_in_ready", in_ready, 1);
    q.delete();
    #1 rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1;
      check("post_rst_no_output", out_valid, 0);
    end
    latency_probe('{20'h00100, 20'h00023, 1'b1, 1'b0}, "post_rst");
    drain();

    // Random traffic with random in_valid / out_ready
    for (int i = 0; i < 10000; i++) begin
      op = '{W'($urandom()), W'($urandom()), 1'($urandom()), 1'($urandom())};
      do_cycle($urandom_range(0, 3) != 0, op, $urandom_range(0, 9) < 7, acc);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
